// File: rtl/ha_array_accum_seq.sv
// Multi-cycle fold of the ha_array (b,t) rows into a PW-bit product.
// Optional op_count port: define HA_ACCUM_SEQ_OPCNT_EN.
module ha_array_accum_seq #(
  parameter int ROWS_PER_CYCLE = 1,
  parameter int PW             = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    x,
  input  logic [7:0]    y,
  output logic [7:0]    dp_x,
  output logic [7:0]    dp_y,
  input  logic [6:0]    ha_b0,
  input  logic [6:0]    ha_b1,
  input  logic [6:0]    ha_b2,
  input  logic [6:0]    ha_b3,
  input  logic [8:0]    ha_t0,
  input  logic [8:0]    ha_t1,
  input  logic [8:0]    ha_t2,
  input  logic [8:0]    ha_t3,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] product,
  output logic          busy
`ifdef HA_ACCUM_SEQ_OPCNT_EN
  ,
  output logic [15:0]   op_count
`endif
);

  if (!(ROWS_PER_CYCLE == 1 ||
        ROWS_PER_CYCLE == 2 ||
        ROWS_PER_CYCLE == 4) || PW < 16)
  begin : g_bad_cfg
    $error("ha_array_accum_seq: bad parameters");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } state_t;

  localparam logic [2:0] STEP = 3'(ROWS_PER_CYCLE);

  state_t        state;
  logic [PW-1:0] acc;
  logic [2:0]    row;
  logic [PW-1:0] term [4];
  logic [PW-1:0] fold;

  always_comb begin
    term[0] = PW'(ha_t0) + (PW'(ha_b0) << 2);
    term[1] = (PW'(ha_t1) + (PW'(ha_b1) << 2)) << 2;
    term[2] = (PW'(ha_t2) + (PW'(ha_b2) << 2)) << 4;
    term[3] = (PW'(ha_t3) + (PW'(ha_b3) << 2)) << 6;
  end

  // row always steps by ROWS_PER_CYCLE, which divides 4
  always_comb begin
    fold = '0;
    for (int j = 0; j < ROWS_PER_CYCLE; j++) begin
      fold = fold + term[row[1:0] + 2'(j)];
    end
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      row       <= '0;
      product   <= '0;
      dp_x      <= '0;
      dp_y      <= '0;
      out_valid <= 1'b0;
`ifdef HA_ACCUM_SEQ_OPCNT_EN
      op_count  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            dp_x  <= x;
            dp_y  <= y;
            acc   <= '0;
            row   <= '0;
            state <= ACC;
          end
        end
        ACC: begin
          if (row[2]) begin
            product   <= acc;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            acc <= acc + fold;
            row <= row + STEP;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
`ifdef HA_ACCUM_SEQ_OPCNT_EN
            op_count  <= op_count + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ha_array_accum_seq.sv
// Random and directed checks of ha_array_accum_seq for
// ROWS_PER_CYCLE 1, 2 and 4 against a row-sum model.
module tb_ha_array_accum_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  xi;
  logic [7:0]  yi;

  logic [7:0]  dpx [3];
  logic [7:0]  dpy [3];
  logic [6:0]  hb [3][4];
  logic [8:0]  ht [3][4];
  logic        ir [3];
  logic        ov [3];
  logic        bz [3];
  logic [15:0] prod [3];
`ifdef HA_ACCUM_SEQ_OPCNT_EN
  logic [15:0] opc [3];
`endif

  int total = 0;
  int bad   = 0;
  int ops   = 0;
  int lat_exp [3] = '{5, 3, 2};

  always #5 clk = ~clk;

  // behavioural stand-in for the ha_array datapath
  function automatic logic [8:0] f_t(
    input logic [7:0] a, input logic [7:0] b, input int i);
    return {1'b0, a & {8{b[2*i]}}};
  endfunction

  function automatic logic [6:0] f_b(
    input logic [7:0] a, input logic [7:0] b, input int i);
    return a[7:1] & {7{b[2*i+1]}};
  endfunction

  function automatic logic [15:0] ref_prod(
    input logic [7:0] a, input logic [7:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      s += (int'(f_t(a, b, i)) + 4 * int'(f_b(a, b, i)))
           * (4 ** i);
    end
    return s[15:0];
  endfunction

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 4; i++) begin
        ht[k][i] = f_t(dpx[k], dpy[k], i);
        hb[k][i] = f_b(dpx[k], dpy[k], i);
      end
    end
  end

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int R = (k == 0) ? 1 : (k == 1) ? 2 : 4;
    ha_array_accum_seq #(
      .ROWS_PER_CYCLE(R),
      .PW(16)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (ir[k]),
      .x        (xi),
      .y        (yi),
      .dp_x     (dpx[k]),
      .dp_y     (dpy[k]),
      .ha_b0    (hb[k][0]),
      .ha_b1    (hb[k][1]),
      .ha_b2    (hb[k][2]),
      .ha_b3    (hb[k][3]),
      .ha_t0    (ht[k][0]),
      .ha_t1    (ht[k][1]),
      .ha_t2    (ht[k][2]),
      .ha_t3    (ht[k][3]),
      .out_valid(ov[k]),
      .out_ready(out_ready),
      .product  (prod[k]),
      .busy     (bz[k])
`ifdef HA_ACCUM_SEQ_OPCNT_EN
      ,
      .op_count (opc[k])
`endif
    );
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(ir[0] && ir[1] && ir[2]) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("idle_timeout", 0, 1);
  endtask

  task automatic start_op(input logic [7:0] a,
                          input logic [7:0] b);
    @(negedge clk);
    wait_idle();
    xi       = a;
    yi       = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    xi       = ~a;
    yi       = ~b;
  endtask

  task automatic do_op(input logic [7:0] a,
                       input logic [7:0] b,
                       input logic [15:0] exp);
    int lat [3] = '{0, 0, 0};
    start_op(a, b);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (ov[k] && lat[k] == 0) begin
          lat[k] = c;
          chk($sformatf("prod%0d", k), 32'(prod[k]),
              32'(exp));
        end
      end
    end
    for (int k = 0; k < 3; k++)
      chk($sformatf("lat%0d", k), lat[k], lat_exp[k]);
    ops++;
  endtask

  initial begin
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] e;
    int          hits;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    xi        = 8'h00;
    yi        = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 32'(ir[k]), 1);
      chk("rst_out_valid", 32'(ov[k]), 0);
      chk("rst_product", 32'(prod[k]), 0);
      chk("rst_busy", 32'(bz[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h01, 8'h01, 16'h0001);
    do_op(8'h04, 8'h01, 16'h0004);
    do_op(8'h00, 8'hFF, 16'h0000);
    do_op(8'hFF, 8'hFF, ref_prod(8'hFF, 8'hFF));

    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      do_op(a, b, ref_prod(a, b));
    end

    // backpressure: hold DONE, poke in_valid
    out_ready = 1'b0;
    a = 8'hA7;
    b = 8'h5D;
    e = ref_prod(a, b);
    start_op(a, b);
    repeat (6) @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      xi       = 8'($urandom);
      yi       = 8'($urandom);
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        chk("bp_valid", 32'(ov[k]), 1);
        chk("bp_prod", 32'(prod[k]), 32'(e));
        chk("bp_ready", 32'(ir[k]), 0);
        chk("bp_busy", 32'(bz[k]), 1);
        chk("bp_dpx", 32'(dpx[k]), 32'(a));
      end
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("bp_rel_valid", 32'(ov[k]), 0);
      chk("bp_rel_ready", 32'(ir[k]), 1);
    end
    ops++;
    do_op(8'h33, 8'hC9, ref_prod(8'h33, 8'hC9));

    // reset at the second ACC edge
    start_op(8'hEE, 8'h77);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("mrst_ready", 32'(ir[k]), 1);
      chk("mrst_prod", 32'(prod[k]), 0);
      chk("mrst_busy", 32'(bz[k]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    hits  = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) if (ov[k]) hits++;
    end
    chk("mrst_no_valid", hits, 0);
    ops = 0;

    for (int n = 0; n < 20; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      do_op(a, b, ref_prod(a, b));
    end

`ifdef HA_ACCUM_SEQ_OPCNT_EN
    for (int k = 0; k < 3; k++)
      chk("op_count", 32'(opc[k]), 32'(ops[15:0]));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
